freq_counter_ctrl_mc: RTL

Multi-channel, parametrised control block for the frequency counter, sitting between the Avalon-MM register bus and the counter core. It scans up to NCHAN input channels selected by a mask and runs one measurement per channel. Each result is queued with its channel index in a FIFO, and an interrupt is raised on scan completion or FIFO overflow. Single-shot and continuous (repeating) scan modes are both supported.

---
 rtl/freq_counter_ctrl_mc_if.sv | 23 ++
 rtl/freq_counter_ctrl_mc.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/freq_counter_ctrl_mc_if.sv
// Avalon-MM register bus between the host and the frequency counter scan controller.
// Reads return registered data one cycle after the read strobe; writes complete in the strobe cycle.
interface freq_counter_ctrl_mc_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] address;
    logic                  read;
    logic [DATA_WIDTH-1:0] readdata;
    logic                  readdatavalid;
    logic                  write;
    logic [DATA_WIDTH-1:0] writedata;

    modport master (
        output address, read, write, writedata,
        input  readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, writedata,
        output readdata, readdatavalid
    );
endinterface

// File: rtl/freq_counter_ctrl_mc.sv
// Multi-channel frequency counter scan controller with a result FIFO and a level interrupt.
// Latency: reads 1 cycle; start->enable 2 cycles; done_flag->next channel CLR 3 cycles, irq +4.
// Backpressure: none on the bus; results arriving at a full FIFO are dropped and flagged as overflow.
module freq_counter_ctrl_mc #(
    parameter int  ADDR_WIDTH = 8,
    parameter int  DATA_WIDTH = 16,
    parameter int  NCHAN      = 4,
    parameter int  FIFO_DEPTH = 8,
    localparam int CW         = (NCHAN > 2) ? $clog2(NCHAN) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    freq_counter_ctrl_mc_if.slave  bus,
    output logic                   irq,
    output logic [CW-1:0]          select_input,
    output logic [DATA_WIDTH-1:0]  samples_required,
    output logic                   enable,
    output logic                   nResetOut,
    input  logic                   done_flag,
    input  logic [DATA_WIDTH-1:0]  out_value
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, CLR, RUN, STORE, NEXT} state_t;

    state_t                state, state_nxt;
    logic [NCHAN-1:0]      chan_mask, lmask;
    logic [DATA_WIDTH-1:0] samples, cap_val, rd_mux;
    logic [1:0]            irq_en, irq_status, irq_set, irq_clr;
    logic                  cont, busy, set_done;
    logic [CW-1:0]         sel_nxt;
    logic [CW:0]           hit_start, hit_up, hit_low;
    logic                  wr_ctrl, start_req, abort_req;

    logic [DATA_WIDTH-1:0] fifo_val [FIFO_DEPTH];
    logic [CW-1:0]         fifo_ch  [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [AW:0]           count;
    logic                  fifo_empty, fifo_full, pop, push_req, push_ok;

    // Returns {found, index} of the lowest set mask bit at or above 'from'.
    function automatic logic [CW:0] first_set(input logic [NCHAN-1:0] m, input int from);
        logic [CW:0] r;
        r = '0;
        for (int i = NCHAN - 1; i >= 0; i--) begin
            if (m[i] && i >= from) r = {1'b1, CW'(i)};
        end
        return r;
    endfunction

    assign busy       = (state != IDLE);
    assign enable     = (state == RUN);
    assign nResetOut  = (state != CLR);
    assign wr_ctrl    = bus.write && (bus.address == ADDR_WIDTH'(3));
    assign start_req  = wr_ctrl && bus.writedata[0] && !busy;
    assign abort_req  = wr_ctrl && bus.writedata[2] && busy;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == (AW+1)'(FIFO_DEPTH));
    assign pop        = bus.read && (bus.address == ADDR_WIDTH'(2)) && !fifo_empty;
    assign push_req   = (state == STORE) && !abort_req;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_ok    = push_req && (!fifo_full || pop);

    assign irq_set    = {push_req && !push_ok, set_done};
    assign irq_clr    = (bus.write && bus.address == ADDR_WIDTH'(4)) ? bus.writedata[1:0] : 2'b00;

    always_comb begin
        state_nxt = state;
        sel_nxt   = select_input;
        set_done  = 1'b0;
        hit_start = first_set(chan_mask, 0);
        hit_up    = first_set(lmask, int'(select_input) + 1);
        hit_low   = first_set(lmask, 0);
        case (state)
            IDLE: begin
                if (start_req) begin
                    if (hit_start[CW]) begin
                        state_nxt = CLR;
                        sel_nxt   = hit_start[CW-1:0];
                    end else begin
                        set_done  = 1'b1;
                    end
                end
            end
            CLR:   state_nxt = RUN;
            RUN:   if (done_flag) state_nxt = STORE;
            STORE: state_nxt = NEXT;
            NEXT: begin
                if (hit_up[CW]) begin
                    state_nxt = CLR;
                    sel_nxt   = hit_up[CW-1:0];
                end else if (cont) begin
                    state_nxt = CLR;
                    sel_nxt   = hit_low[CW-1:0];
                end else begin
                    state_nxt = IDLE;
                    set_done  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (abort_req) begin
            state_nxt = IDLE;
            set_done  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            select_input     <= '0;
            samples_required <= '0;
            lmask            <= '0;
            cont             <= 1'b0;
            cap_val          <= '0;
        end else begin
            state        <= state_nxt;
            select_input <= sel_nxt;
            if (start_req) begin
                lmask            <= chan_mask;
                samples_required <= samples;
                cont             <= bus.writedata[1];
            end else if (abort_req) begin
                cont <= 1'b0;
            end
            // out_value is only guaranteed while done_flag is high, so hold it for STORE.
            if (state == RUN && done_flag) cap_val <= out_value;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chan_mask  <= '0;
            samples    <= '0;
            irq_en     <= '0;
            irq_status <= '0;
            irq        <= 1'b0;
        end else begin
            if (bus.write && bus.address == ADDR_WIDTH'(0)) chan_mask <= bus.writedata[NCHAN-1:0];
            if (bus.write && bus.address == ADDR_WIDTH'(1)) samples   <= bus.writedata;
            if (bus.write && bus.address == ADDR_WIDTH'(6)) irq_en    <= bus.writedata[1:0];
            irq_status <= (irq_status & ~irq_clr) | irq_set;
            irq        <= |(irq_status & irq_en);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_val[wr_ptr] <= cap_val;
            fifo_ch[wr_ptr]  <= select_input;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (bus.address)
            ADDR_WIDTH'(0): rd_mux = DATA_WIDTH'(chan_mask);
            ADDR_WIDTH'(1): rd_mux = samples;
            ADDR_WIDTH'(2): if (!fifo_empty) rd_mux = fifo_val[rd_ptr];
            ADDR_WIDTH'(3): rd_mux = DATA_WIDTH'({busy, cont});
            ADDR_WIDTH'(4): rd_mux = DATA_WIDTH'(irq_status);
            ADDR_WIDTH'(5): if (!fifo_empty) rd_mux = DATA_WIDTH'(fifo_ch[rd_ptr]);
            ADDR_WIDTH'(6): rd_mux = DATA_WIDTH'(irq_en);
            ADDR_WIDTH'(7): rd_mux = DATA_WIDTH'({8'(count), 5'd0, fifo_full, fifo_empty, busy});
            default:        rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.readdata      <= '0;
            bus.readdatavalid <= 1'b0;
        end else begin
            bus.readdatavalid <= bus.read;
            bus.readdata      <= bus.read ? rd_mux : '0;
        end
    end

endmodule
